fifo_bank: RTL and testbench

FIFO_BANK -- requirements
Module: fifo_bank

---
 rtl/fifo_bank.sv | 92 +++++++++
 tb/tb_fifo_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bank.sv
// fifo_bank: NUM_CH independent first-word-fall-through FIFOs sharing one clock.
// Each channel has its own write/read pointers, occupancy count and sticky
// overflow flag. Status outputs are decoded from the registered count.
//
// Ports:
//   fifo_clk      in   clock, all state updates on the rising edge
//   rst           in   asynchronous active-high reset
//   data_in       in   write data, channel i at [i*DATASIZE +: DATASIZE]
//   valid_in      in   per-channel write request
//   ready_in      in   per-channel read request (pop head)
//   err_clr       in   clears all sticky overflow flags
//   data_out      out  head entry per channel, same packing as data_in
//   valid_out     out  channel non-empty
//   full_out      out  count == DEPTH
//   afull_out     out  count >= AF_THRESH
//   pressure_out  out  occupancy count, channel i at [i*(WIDTH+1) +: WIDTH+1]
//   ovf_out       out  sticky overflow flag
module fifo_bank #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned DATASIZE  = 40,
  parameter int unsigned AF_THRESH = 6
) (
  input  logic                         fifo_clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATASIZE-1:0]   data_in,
  input  logic [NUM_CH-1:0]            valid_in,
  input  logic [NUM_CH-1:0]            ready_in,
  input  logic                         err_clr,
  output logic [NUM_CH*DATASIZE-1:0]   data_out,
  output logic [NUM_CH-1:0]            valid_out,
  output logic [NUM_CH-1:0]            full_out,
  output logic [NUM_CH-1:0]            afull_out,
  output logic [NUM_CH*(WIDTH+1)-1:0]  pressure_out,
  output logic [NUM_CH-1:0]            ovf_out
);

  localparam int unsigned CW = WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CW-1:0]       r_count;
    logic [WIDTH-1:0]    r_wptr;
    logic [WIDTH-1:0]    r_rptr;
    logic                r_ovf;
    logic [DATASIZE-1:0] r_mem [DEPTH];

    logic                w_rd;
    logic                w_wr;
    logic                w_ovf;
    logic [DATASIZE-1:0] w_din;

    assign w_din = data_in[ch*DATASIZE +: DATASIZE];

    // A read on empty is dropped; a write at full is taken only when a read
    // frees the slot in the same cycle, so count stays within 0..DEPTH.
    assign w_rd  = ready_in[ch] & (r_count != '0);
    assign w_wr  = valid_in[ch] & ((r_count != DEPTH_C) | w_rd);
    assign w_ovf = valid_in[ch] & ~w_wr;

    // Pointers, count and sticky overflow; a new overflow beats err_clr.
    always_ff @(posedge fifo_clk or posedge rst) begin
      if (rst) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_wr) r_wptr <= r_wptr + WIDTH'(1);
        if (w_rd) r_rptr <= r_rptr + WIDTH'(1);
        r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        if (w_ovf)        r_ovf <= 1'b1;
        else if (err_clr) r_ovf <= 1'b0;
      end
    end

    // Storage is not reset; only locations below count are ever observed.
    always_ff @(posedge fifo_clk) begin
      if (w_wr) r_mem[r_wptr] <= w_din;
    end

    assign data_out[ch*DATASIZE +: DATASIZE] = r_mem[r_rptr];
    assign valid_out[ch]                     = (r_count != '0);
    assign full_out[ch]                      = (r_count == DEPTH_C);
    assign afull_out[ch]                     = (r_count >= AF_C);
    assign pressure_out[ch*CW +: CW]         = r_count;
    assign ovf_out[ch]                       = r_ovf;
  end

endmodule

// File: tb/tb_fifo_bank.sv
// Testbench for fifo_bank: queue-based reference model, per-cycle compare on
// the falling edge, directed scenarios with literal expectations, then random
// traffic with occasional mid-cycle resets.
module tb_fifo_bank;

  localparam int NCH   = 3;
  localparam int DEPTH = 8;
  localparam int W     = 3;
  localparam int CW    = W + 1;
  localparam int DS    = 40;
  localparam int AF    = 6;

  logic                 fifo_clk;
  logic                 rst;
  logic [NCH*DS-1:0]    data_in;
  logic [NCH-1:0]       valid_in;
  logic [NCH-1:0]       ready_in;
  logic                 err_clr;
  logic [NCH*DS-1:0]    data_out;
  logic [NCH-1:0]       valid_out;
  logic [NCH-1:0]       full_out;
  logic [NCH-1:0]       afull_out;
  logic [NCH*CW-1:0]    pressure_out;
  logic [NCH-1:0]       ovf_out;

  fifo_bank #(.NUM_CH(NCH), .DEPTH(DEPTH), .WIDTH(W), .DATASIZE(DS), .AF_THRESH(AF)) dut (
    .fifo_clk(fifo_clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .err_clr(err_clr), .data_out(data_out), .valid_out(valid_out),
    .full_out(full_out), .afull_out(afull_out), .pressure_out(pressure_out), .ovf_out(ovf_out)
  );

  initial fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  // Reference model: one queue per channel plus sticky overflow bits.
  logic [DS-1:0]  mq [NCH][$];
  logic [NCH-1:0] mov;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    mov = '0;
  endtask

  // Apply the current inputs to the model as one rising edge.
  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit rd;
      bit wr;
      rd = ready_in[c] && (mq[c].size() != 0);
      wr = valid_in[c] && ((mq[c].size() < DEPTH) || rd);
      if (rd) void'(mq[c].pop_front());
      if (wr) mq[c].push_back(data_in[c*DS +: DS]);
      if (valid_in[c] && !wr) mov[c] = 1'b1;
      else if (err_clr)       mov[c] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge fifo_clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic set_din(input int c, input logic [DS-1:0] v);
    data_in[c*DS +: DS] = v;
  endtask

  function automatic logic [CW-1:0] press(input int c);
    return pressure_out[c*CW +: CW];
  endfunction

  function automatic logic [DS-1:0] dout(input int c);
    return data_out[c*DS +: DS];
  endfunction

  // Per-cycle comparison of every channel against the model.
  always @(negedge fifo_clk) begin
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        int n;
        logic [7:0] act;
        logic [7:0] exp;
        n   = mq[c].size();
        act = {valid_out[c], full_out[c], afull_out[c], ovf_out[c], 4'(press(c))};
        exp = {n != 0, n == DEPTH, n >= AF, mov[c], 4'(n)};
        chk($sformatf("status_ch%0d", c), 64'(act), 64'(exp));
        if (n != 0) chk($sformatf("head_ch%0d", c), 64'(dout(c)), 64'(mq[c][0]));
      end
    end
  end

  initial begin
    rst = 1'b1; data_in = '0; valid_in = '0; ready_in = '0; err_clr = 1'b0;
    model_clear();
    tick(); tick();
    chk("reset_outputs", 64'({valid_out, full_out, afull_out, ovf_out, pressure_out}), 64'(0));
    rst = 1'b0;

    // Fill ch0 with 0x01..0x08.
    for (int i = 1; i <= 8; i++) begin
      set_din(0, DS'(i)); valid_in = 3'b001;
      tick();
      chk("fill_press0", 64'(press(0)), 64'(i));
      chk("fill_afull0", 64'(afull_out[0]), 64'(i >= 6));
      chk("fill_full0", 64'(full_out[0]), 64'(i == 8));
      chk("fill_other", 64'({press(1), press(2)}), 64'(0));
    end
    chk("model_pin_size", 64'(mq[0].size()), 64'(8));

    // Ninth write is an overflow and is discarded.
    set_din(0, DS'(8'hFF)); tick();
    valid_in = '0;
    chk("ovf_press0", 64'(press(0)), 64'(8));
    chk("ovf_flag0", 64'(ovf_out[0]), 64'(1));
    ready_in = 3'b001;
    for (int i = 1; i <= 8; i++) begin
      chk("drain0", 64'(dout(0)), 64'(i));
      tick();
    end
    ready_in = '0;
    chk("drained_valid0", 64'(valid_out[0]), 64'(0));
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_ovf0", 64'(ovf_out[0]), 64'(0));

    // Full ch0 with simultaneous read and write across the pointer wrap.
    valid_in = 3'b001;
    for (int i = 0; i < 8; i++) begin set_din(0, DS'(8'h10 + i)); tick(); end
    ready_in = 3'b001;
    for (int k = 0; k < 5; k++) begin
      set_din(0, DS'(8'h18 + k));
      chk("rw_head0", 64'(dout(0)), 64'(8'h10 + k));
      tick();
      chk("rw_press0", 64'(press(0)), 64'(8));
    end
    valid_in = '0;
    chk("rw_noovf0", 64'(ovf_out[0]), 64'(0));
    for (int k = 0; k < 8; k++) begin
      chk("rw_drain0", 64'(dout(0)), 64'(8'h15 + k));
      tick();
    end
    ready_in = '0;

    // Read on empty ch2 is ignored; then a single write falls through.
    ready_in = 3'b100; tick(); ready_in = '0;
    chk("empty_rd2", 64'({valid_out[2], ovf_out[2], press(2)}), 64'(0));
    set_din(2, DS'(8'hAB)); valid_in = 3'b100; tick(); valid_in = '0;
    chk("fwft_valid2", 64'(valid_out[2]), 64'(1));
    chk("fwft_data2", 64'(dout(2)), 64'(8'hAB));

    // Overflow set wins over a simultaneous err_clr.
    valid_in = 3'b010;
    for (int i = 0; i < 9; i++) begin set_din(1, DS'(8'h40 + i)); tick(); end
    chk("ovf_flag1", 64'(ovf_out[1]), 64'(1));
    err_clr = 1'b1; tick();
    chk("set_wins1", 64'(ovf_out[1]), 64'(1));
    valid_in = '0; tick(); err_clr = 1'b0;
    chk("clr_alone1", 64'(ovf_out[1]), 64'(0));
    ready_in = 3'b010; repeat (8) tick(); ready_in = '0;

    // Reset between edges discards everything at once.
    valid_in = 3'b001;
    for (int i = 0; i < 5; i++) begin set_din(0, DS'(8'h50 + i)); tick(); end
    valid_in = '0;
    #2 rst = 1'b1; model_clear();
    #1 chk("async_rst", 64'({valid_out, full_out, afull_out, ovf_out, pressure_out}), 64'(0));
    tick();
    rst = 1'b0;
    set_din(0, DS'(8'h3C)); valid_in = 3'b001; tick(); valid_in = '0;
    chk("post_rst_press0", 64'(press(0)), 64'(1));
    chk("post_rst_head0", 64'(dout(0)), 64'(8'h3C));

    // Random traffic, biased phases to reach both full and empty often.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int wp;
      wp = ((cyc / 150) % 2 == 0) ? 75 : 30;
      for (int c = 0; c < NCH; c++) begin
        set_din(c, {8'($urandom), $urandom});
        valid_in[c] = ($urandom_range(99) < wp);
        ready_in[c] = ($urandom_range(99) < 100 - wp);
      end
      err_clr = ($urandom_range(99) < 5);
      if ($urandom_range(399) == 0) begin
        #2 rst = 1'b1; model_clear();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    valid_in = '0; ready_in = '0; err_clr = 1'b0;
    tick(); tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
